// File: rtl/cic_decimator_param_if.sv
// rtl/cic_decimator_param_if.sv - sample, control and status bundle for the CIC decimator
// master drives samples and runtime controls; slave is the decimator.
interface cic_decimator_param_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 8
);
    logic [15:0]             dec_ratio;
    logic [6:0]              out_shift;
    logic                    in_valid;
    logic signed [IN_W-1:0]  d_in;
    logic                    out_valid;
    logic signed [OUT_W-1:0] d_out;
    logic                    ratio_err;

    modport master (
        output dec_ratio, out_shift, in_valid, d_in,
        input  out_valid, d_out, ratio_err
    );

    modport slave (
        input  dec_ratio, out_shift, in_valid, d_in,
        output out_valid, d_out, ratio_err
    );
endinterface

// File: rtl/cic_decimator_param.sv
// rtl/cic_decimator_param.sv - N-stage CIC decimator with runtime ratio, shift, rounding and saturation
// Integrators run at the input sample rate; combs run on a valid-qualified pipeline at the output rate.
module cic_decimator_param #(
    parameter int IN_W       = 8,
    parameter int OUT_W      = 8,
    parameter int N          = 5,
    parameter int DIFF_DELAY = 1,
    parameter int R_MAX      = 4096,
    parameter int ACC_W      = IN_W + N * $clog2(R_MAX * DIFF_DELAY)
) (
    input  logic                  clk,
    input  logic                  rst,
    cic_decimator_param_if.slave  bus
);

    localparam logic [16:0]             R_MAX_L = 17'(R_MAX);
    localparam logic signed [ACC_W:0]   SAT_HI  = {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0]   SAT_LO  = ~SAT_HI;
    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

    function automatic logic ratio_ok(input logic [15:0] r);
        return (r != 16'd0) && ({1'b0, r} <= R_MAX_L);
    endfunction

    logic signed [ACC_W-1:0] integ_q [N];
    logic signed [ACC_W-1:0] integ_d [N];
    logic [15:0]             cnt_q, cnt_d;
    logic [15:0]             r_q, r_d;
    logic                    load_q, load_d;
    logic                    err_q, err_d;
    logic signed [ACC_W-1:0] cap_q, cap_d;
    logic                    cap_valid_q, cap_valid_d;

    logic signed [ACC_W-1:0] comb_q [N];
    logic signed [ACC_W-1:0] comb_d [N];
    logic signed [ACC_W-1:0] dly_q [N][DIFF_DELAY];
    logic signed [ACC_W-1:0] dly_d [N][DIFF_DELAY];
    logic [N-1:0]            cv_q, cv_d;

    logic signed [OUT_W-1:0] d_out_q, d_out_d;
    logic                    out_valid_q, out_valid_d;

    logic [15:0]             r_eff;
    logic signed [ACC_W-1:0] sext_in;
    logic signed [ACC_W-1:0] stage_in [N];
    logic [N-1:0]            stage_v;
    logic signed [ACC_W-1:0] c_last;
    logic signed [ACC_W-1:0] shifted;
    logic [6:0]              rnd_idx;
    logic                    rnd;
    logic signed [ACC_W:0]   y;

    // The first clock after reset loads the ratio; a sample accepted on that
    // same clock already uses the freshly presented value.
    always_comb begin
        integ_d     = integ_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        load_d      = 1'b0;
        err_d       = err_q;
        cap_d       = cap_q;
        cap_valid_d = 1'b0;
        r_eff       = load_q ? bus.dec_ratio : r_q;
        sext_in     = {{(ACC_W - IN_W){bus.d_in[IN_W-1]}}, bus.d_in};

        if (load_q) begin
            r_d = bus.dec_ratio;
        end

        if (bus.in_valid) begin
            integ_d[0] = integ_q[0] + sext_in;
            for (int k = 1; k < N; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end

            if (!ratio_ok(r_eff)) begin
                // Illegal ratio: hold the window closed, keep sampling the control for recovery.
                cnt_d = 16'd0;
                r_d   = bus.dec_ratio;
                err_d = !ratio_ok(bus.dec_ratio);
            end else if (cnt_q == r_eff - 16'd1) begin
                cap_d       = integ_q[N-1];
                cap_valid_d = 1'b1;
                cnt_d       = 16'd0;
                r_d         = bus.dec_ratio;
                err_d       = !ratio_ok(bus.dec_ratio);
            end else begin
                cnt_d = cnt_q + 16'd1;
                err_d = 1'b0;
            end
        end
    end

    always_comb begin
        stage_in[0] = cap_q;
        stage_v[0]  = cap_valid_q;
        for (int k = 1; k < N; k++) begin
            stage_in[k] = comb_q[k-1];
            stage_v[k]  = cv_q[k-1];
        end
    end

    // Each comb stage and its delay line advance only when its input is valid.
    always_comb begin
        comb_d = comb_q;
        dly_d  = dly_q;
        cv_d   = '0;
        for (int k = 0; k < N; k++) begin
            cv_d[k] = stage_v[k];
            if (stage_v[k]) begin
                comb_d[k]   = stage_in[k] - dly_q[k][DIFF_DELAY-1];
                dly_d[k][0] = stage_in[k];
                for (int j = 1; j < DIFF_DELAY; j++) begin
                    dly_d[k][j] = dly_q[k][j-1];
                end
            end
        end
    end

    // Shifts past the accumulator width reduce to sign fill, so the rounding bit is the sign bit.
    always_comb begin
        c_last      = comb_q[N-1];
        shifted     = c_last >>> bus.out_shift;
        rnd_idx     = (bus.out_shift > 7'(ACC_W)) ? 7'(ACC_W - 1) : 7'(bus.out_shift - 7'd1);
        rnd         = (bus.out_shift != 7'd0) && c_last[rnd_idx];
        y           = {shifted[ACC_W-1], shifted} + {{ACC_W{1'b0}}, rnd};
        out_valid_d = cv_q[N-1];
        d_out_d     = d_out_q;
        if (cv_q[N-1]) begin
            if (y > SAT_HI) begin
                d_out_d = OUT_MAX;
            end else if (y < SAT_LO) begin
                d_out_d = OUT_MIN;
            end else begin
                d_out_d = y[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                integ_q[k] <= '0;
                comb_q[k]  <= '0;
                for (int j = 0; j < DIFF_DELAY; j++) begin
                    dly_q[k][j] <= '0;
                end
            end
            cv_q        <= '0;
            cnt_q       <= '0;
            r_q         <= '0;
            load_q      <= 1'b1;
            err_q       <= 1'b0;
            cap_q       <= '0;
            cap_valid_q <= 1'b0;
            d_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            integ_q     <= integ_d;
            comb_q      <= comb_d;
            dly_q       <= dly_d;
            cv_q        <= cv_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            load_q      <= load_d;
            err_q       <= err_d;
            cap_q       <= cap_d;
            cap_valid_q <= cap_valid_d;
            d_out_q     <= d_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.d_out     = d_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ratio_err = err_q;

endmodule
